// File: rtl/fifo_fwft_mbank_pkg.sv
// Shared constants and elaboration-time helpers for the banked FWFT FIFO.
package fifo_fwft_pkg;

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  function automatic int bank_sel_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit fifo_cfg_ok(input int depth, input int banks);
    return is_pow2(depth) && is_pow2(banks) && (banks >= 2) &&
           (depth >= banks) && ((depth % banks) == 0);
  endfunction

endpackage

// File: rtl/fifo_fwft_mbank_if.sv
// Producer/consumer handshake bundle for fifo_fwft_mbank; slave is the FIFO side.
interface fifo_fwft_mbank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  flush_i;
  logic                  wen_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  full_o;
  logic                  afull_o;
  logic                  ren_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  empty_o;
  logic                  aempty_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic [1:0]            err_o;

  modport slave (
    input  flush_i, wen_i, wdata_i, ren_i,
    output full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, err_o
  );

  modport master (
    output flush_i, wen_i, wdata_i, ren_i,
    input  full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, err_o
  );
endinterface

// File: rtl/fifo_fwft_mbank_spram_bank.sv
// One FIFO bank: single-port RAM plus a 1-entry prefetch register; head visible 2 cycles
// after a write into an empty bank; full_o when RAM + prefetch hold DEPTH entries.
module fifo_spram_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  input  logic                  ren_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wa, r_ra;
  logic [CW-1:0]         r_ram_cnt, r_occ;
  logic                  r_pf_vld;
  logic [DATA_WIDTH-1:0] r_pf_dat;
  logic                  w_push, w_pop, w_fill;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  assign full_o  = (r_occ == CW'(DEPTH));
  assign empty_o = ~r_pf_vld;
  assign rdata_o = r_pf_dat;

  assign w_push = wen_i & ~full_o & ~flush_i;
  assign w_pop  = ren_i & r_pf_vld & ~flush_i;
  // The RAM port is single: a write owns it, the prefetch refill waits a cycle.
  assign w_fill = (r_ram_cnt != '0) & ~w_push & (~r_pf_vld | w_pop) & ~flush_i;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wa] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wa      <= '0;
      r_ra      <= '0;
      r_ram_cnt <= '0;
      r_occ     <= '0;
      r_pf_vld  <= 1'b0;
      r_pf_dat  <= '0;
    end else if (flush_i) begin
      r_wa      <= '0;
      r_ra      <= '0;
      r_ram_cnt <= '0;
      r_occ     <= '0;
      r_pf_vld  <= 1'b0;
      r_pf_dat  <= '0;
    end else begin
      if (w_push) r_wa <= next_addr(r_wa);
      if (w_fill) begin
        r_ra     <= next_addr(r_ra);
        r_pf_dat <= r_mem[r_ra];
        r_pf_vld <= 1'b1;
      end else if (w_pop) begin
        r_pf_vld <= 1'b0;
      end
      if (w_push & ~w_fill)      r_ram_cnt <= r_ram_cnt + CW'(1);
      else if (w_fill & ~w_push) r_ram_cnt <= r_ram_cnt - CW'(1);
      if (w_push & ~w_pop)       r_occ <= r_occ + CW'(1);
      else if (w_pop & ~w_push)  r_occ <= r_occ - CW'(1);
    end
  end
endmodule

// File: rtl/fifo_fwft_mbank.sv
// Banked FWFT FIFO, writes/reads rotate round-robin over NUM_BANKS single-port banks.
// Optional sticky {overflow, underflow} flags when FIFO_FWFT_ERR_FLAGS_EN is defined.
module fifo_fwft_mbank
  import fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int AEMPTY_THR = 4,
  parameter int AFULL_THR  = 28
) (
  input logic              clk,
  input logic              rst,
  fifo_fwft_mbank_if.slave io_fifo
);
  localparam int BSW        = bank_sel_w(NUM_BANKS);
  localparam int BANK_DEPTH = FIFO_DEPTH / NUM_BANKS;

  generate
    if (!fifo_cfg_ok(FIFO_DEPTH, NUM_BANKS)) begin : g_bad_cfg
      $error("fifo_fwft_mbank: FIFO_DEPTH/NUM_BANKS must be powers of two, NUM_BANKS>=2");
    end
  endgenerate

  logic [ADDR_WIDTH:0]   r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   w_count;
  logic [BSW-1:0]        w_wsel, w_rsel;
  logic [NUM_BANKS-1:0]  w_bank_full, w_bank_empty;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_wsel   = r_wptr[BSW-1:0];
  assign w_rsel   = r_rptr[BSW-1:0];
  assign w_full   = w_bank_full[w_wsel];
  assign w_empty  = w_bank_empty[w_rsel];
  assign w_wr_acc = io_fifo.wen_i & ~w_full & ~io_fifo.flush_i;
  assign w_rd_acc = io_fifo.ren_i & ~w_empty & ~io_fifo.flush_i;
  // Pointers wrap at 2*FIFO_DEPTH, so their difference is the occupancy.
  assign w_count  = r_wptr - r_rptr;

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      fifo_spram_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BANK_DEPTH)
      ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .flush_i(io_fifo.flush_i),
        .wen_i  (io_fifo.wen_i & (w_wsel == BSW'(g))),
        .wdata_i(io_fifo.wdata_i),
        .full_o (w_bank_full[g]),
        .ren_i  (io_fifo.ren_i & (w_rsel == BSW'(g))),
        .rdata_o(w_bank_rdata[g]),
        .empty_o(w_bank_empty[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (io_fifo.flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + (ADDR_WIDTH+1)'(1);
      if (w_rd_acc) r_rptr <= r_rptr + (ADDR_WIDTH+1)'(1);
    end
  end

  assign io_fifo.full_o   = w_full;
  assign io_fifo.empty_o  = w_empty;
  assign io_fifo.rdata_o  = w_bank_rdata[w_rsel];
  assign io_fifo.count_o  = w_count;
  assign io_fifo.afull_o  = (w_count >= (ADDR_WIDTH+1)'(AFULL_THR));
  assign io_fifo.aempty_o = (w_count <= (ADDR_WIDTH+1)'(AEMPTY_THR));

`ifdef FIFO_FWFT_ERR_FLAGS_EN
  logic [1:0] r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 2'b00;
    end else begin
      if (io_fifo.wen_i & w_full & ~io_fifo.flush_i)  r_err[ERR_OVF] <= 1'b1;
      if (io_fifo.ren_i & w_empty & ~io_fifo.flush_i) r_err[ERR_UDF] <= 1'b1;
    end
  end

  assign io_fifo.err_o = r_err;
`else
  assign io_fifo.err_o = 2'b00;
`endif
endmodule

// File: tb/tb_fifo_fwft_mbank.sv
// Directed bench for fifo_fwft_mbank (32 entries, 4 banks, 8-bit data).
module tb_fifo_fwft_mbank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

`ifdef FIFO_FWFT_ERR_FLAGS_EN
  localparam logic [1:0] EXP_OVF  = 2'b10;
  localparam logic [1:0] EXP_BOTH = 2'b11;
`else
  localparam logic [1:0] EXP_OVF  = 2'b00;
  localparam logic [1:0] EXP_BOTH = 2'b00;
`endif

  always #5 clk = ~clk;

  fifo_fwft_mbank_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  fifo_fwft_mbank #(
    .DATA_WIDTH(8), .FIFO_DEPTH(32), .NUM_BANKS(4), .AEMPTY_THR(4), .AFULL_THR(28)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_fifo(bus)
  );

  task automatic idle();
    bus.wen_i = 1'b0; bus.ren_i = 1'b0; bus.flush_i = 1'b0; bus.wdata_i = 8'h00;
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wen_i = 1'b1; bus.wdata_i = base + 8'(i);
      @(negedge clk);
    end
    bus.wen_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++; if (bus.empty_o !== 1'b1)  begin failures++; $display("FAIL rst_empty got=%0b exp=1", bus.empty_o); end
    checks++; if (bus.full_o !== 1'b0)   begin failures++; $display("FAIL rst_full got=%0b exp=0", bus.full_o); end
    checks++; if (bus.aempty_o !== 1'b1) begin failures++; $display("FAIL rst_aempty got=%0b exp=1", bus.aempty_o); end
    checks++; if (bus.afull_o !== 1'b0)  begin failures++; $display("FAIL rst_afull got=%0b exp=0", bus.afull_o); end
    checks++; if (bus.count_o !== 6'd0)  begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.err_o !== 2'b00)   begin failures++; $display("FAIL rst_err got=%0b exp=00", bus.err_o); end
    checks++; if (bus.rdata_o !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%0h exp=00", bus.rdata_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fwft_latency();
    bus.wen_i = 1'b1; bus.wdata_i = 8'hA5;
    @(negedge clk);
    bus.wen_i = 1'b0;
    checks++; if (bus.count_o !== 6'd1) begin failures++; $display("FAIL lat_count_n1 got=%0d exp=1", bus.count_o); end
    checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL lat_empty_n1 got=%0b exp=1", bus.empty_o); end
    @(negedge clk);
    checks++; if (bus.empty_o !== 1'b0)  begin failures++; $display("FAIL lat_empty_n2 got=%0b exp=0", bus.empty_o); end
    checks++; if (bus.rdata_o !== 8'hA5) begin failures++; $display("FAIL lat_rdata_n2 got=%0h exp=a5", bus.rdata_o); end
    bus.ren_i = 1'b1;
    @(negedge clk);
    bus.ren_i = 1'b0;
    checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL lat_pop_empty got=%0b exp=1", bus.empty_o); end
    checks++; if (bus.count_o !== 6'd0) begin failures++; $display("FAIL lat_pop_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus.full_o !== 1'b0) begin failures++; $display("FAIL fill_full_early i=%0d got=1 exp=0", i); end
      bus.wen_i = 1'b1; bus.wdata_i = 8'(i);
      @(negedge clk);
      if (i == 26) begin
        checks++; if (bus.afull_o !== 1'b0) begin failures++; $display("FAIL afull_at27 got=%0b exp=0", bus.afull_o); end
      end
      if (i == 27) begin
        checks++; if (bus.afull_o !== 1'b1) begin failures++; $display("FAIL afull_at28 got=%0b exp=1", bus.afull_o); end
      end
    end
    bus.wen_i = 1'b0;
    checks++; if (bus.full_o !== 1'b1)   begin failures++; $display("FAIL fill_full got=%0b exp=1", bus.full_o); end
    checks++; if (bus.count_o !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", bus.count_o); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (bus.empty_o !== 1'b0)    begin failures++; $display("FAIL drain_empty i=%0d got=1 exp=0", i); end
      checks++; if (bus.rdata_o !== 8'(i))   begin failures++; $display("FAIL drain_data i=%0d got=%0h exp=%0h", i, bus.rdata_o, 8'(i)); end
      bus.ren_i = 1'b1;
      @(negedge clk);
      if (i == 27) begin
        checks++; if (bus.aempty_o !== 1'b1) begin failures++; $display("FAIL aempty_at4 got=%0b exp=1", bus.aempty_o); end
      end
      if (i == 26) begin
        checks++; if (bus.aempty_o !== 1'b0) begin failures++; $display("FAIL aempty_at5 got=%0b exp=0", bus.aempty_o); end
      end
    end
    bus.ren_i = 1'b0;
    checks++; if (bus.empty_o !== 1'b1)  begin failures++; $display("FAIL drain_end_empty got=%0b exp=1", bus.empty_o); end
    checks++; if (bus.aempty_o !== 1'b1) begin failures++; $display("FAIL drain_end_aempty got=%0b exp=1", bus.aempty_o); end
    checks++; if (bus.count_o !== 6'd0)  begin failures++; $display("FAIL drain_end_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_back_to_back();
    fill(8, 8'h00);
    for (int i = 0; i < 100; i++) begin
      checks++; if (bus.empty_o !== 1'b0 || bus.full_o !== 1'b0) begin failures++; $display("FAIL b2b_stall i=%0d empty=%0b full=%0b exp=0/0", i, bus.empty_o, bus.full_o); end
      checks++; if (bus.rdata_o !== 8'(i)) begin failures++; $display("FAIL b2b_data i=%0d got=%0h exp=%0h", i, bus.rdata_o, 8'(i)); end
      bus.wen_i = 1'b1; bus.ren_i = 1'b1; bus.wdata_i = 8'(i + 8);
      @(negedge clk);
      checks++; if (bus.count_o !== 6'd8) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=8", i, bus.count_o); end
    end
    idle();
    do_flush();
  endtask

  task automatic test_overflow_underflow();
    fill(32, 8'h00);
    bus.wen_i = 1'b1; bus.wdata_i = 8'hFF;
    @(negedge clk);
    bus.wen_i = 1'b0;
    checks++; if (bus.count_o !== 6'd32) begin failures++; $display("FAIL ovf_count got=%0d exp=32", bus.count_o); end
    checks++; if (bus.full_o !== 1'b1)   begin failures++; $display("FAIL ovf_full got=%0b exp=1", bus.full_o); end
    checks++; if (bus.rdata_o !== 8'h00) begin failures++; $display("FAIL ovf_head got=%0h exp=00", bus.rdata_o); end
    checks++; if (bus.err_o !== EXP_OVF) begin failures++; $display("FAIL ovf_err got=%0b exp=%0b", bus.err_o, EXP_OVF); end
    do_flush();
    checks++; if (bus.err_o !== EXP_OVF) begin failures++; $display("FAIL flush_keeps_err got=%0b exp=%0b", bus.err_o, EXP_OVF); end
    checks++; if (bus.empty_o !== 1'b1)  begin failures++; $display("FAIL ovf_flush_empty got=%0b exp=1", bus.empty_o); end
    bus.ren_i = 1'b1;
    @(negedge clk);
    bus.ren_i = 1'b0;
    checks++; if (bus.err_o !== EXP_BOTH) begin failures++; $display("FAIL udf_err got=%0b exp=%0b", bus.err_o, EXP_BOTH); end
    checks++; if (bus.count_o !== 6'd0)   begin failures++; $display("FAIL udf_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_flush_priority();
    fill(10, 8'h80);
    @(negedge clk);
    checks++; if (bus.count_o !== 6'd10) begin failures++; $display("FAIL flp_prefill got=%0d exp=10", bus.count_o); end
    bus.flush_i = 1'b1; bus.wen_i = 1'b1; bus.ren_i = 1'b1; bus.wdata_i = 8'h55;
    @(negedge clk);
    idle();
    checks++; if (bus.count_o !== 6'd0) begin failures++; $display("FAIL flp_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL flp_empty got=%0b exp=1", bus.empty_o); end
    repeat (2) @(negedge clk);
    checks++; if (bus.empty_o !== 1'b1 || bus.count_o !== 6'd0) begin failures++; $display("FAIL flp_no_write got empty=%0b count=%0d exp=1/0", bus.empty_o, bus.count_o); end
  endtask

  task automatic test_async_reset();
    fill(12, 8'h20);
    @(negedge clk);
    checks++; if (bus.count_o !== 6'd12 || bus.empty_o !== 1'b0) begin failures++; $display("FAIL ar_prefill count=%0d empty=%0b exp=12/0", bus.count_o, bus.empty_o); end
    bus.wen_i = 1'b1; bus.wdata_i = 8'h99;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.count_o !== 6'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin failures++; $display("FAIL ar_now count=%0d empty=%0b full=%0b exp=0/1/0", bus.count_o, bus.empty_o, bus.full_o); end
    checks++; if (bus.rdata_o !== 8'h00 || bus.err_o !== 2'b00 || bus.aempty_o !== 1'b1 || bus.afull_o !== 1'b0) begin failures++; $display("FAIL ar_now_misc rdata=%0h err=%0b aempty=%0b afull=%0b exp=00/00/1/0", bus.rdata_o, bus.err_o, bus.aempty_o, bus.afull_o); end
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.wen_i = 1'b1; bus.wdata_i = 8'h3C;
    @(negedge clk);
    bus.wen_i = 1'b0;
    checks++; if (bus.count_o !== 6'd1 || bus.empty_o !== 1'b1) begin failures++; $display("FAIL ar_w_n1 count=%0d empty=%0b exp=1/1", bus.count_o, bus.empty_o); end
    @(negedge clk);
    checks++; if (bus.empty_o !== 1'b0 || bus.rdata_o !== 8'h3C) begin failures++; $display("FAIL ar_w_n2 empty=%0b rdata=%0h exp=0/3c", bus.empty_o, bus.rdata_o); end
  endtask

  initial begin
    test_reset();
    test_fwft_latency();
    test_fill_drain();
    test_back_to_back();
    test_overflow_underflow();
    test_flush_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_fwft_mbank.md
Name: fifo_fwft_mbank

Overview:
- Synchronous first-word-fall-through FIFO built from NUM_BANKS interleaved single-port-RAM banks. Successive writes and reads rotate round-robin across banks, so no single bank ever sees back-to-back accesses.
- Generalises the two-bank FWFT FIFO to any power-of-two bank count.
- Adds programmable almost-full/almost-empty, synchronous flush, and an optional sticky error flag.
- Sits between producer and consumer stream stages in the datapath.

Parameters:
- DATA_WIDTH, 8, data bits per entry
- FIFO_DEPTH, 32, total entries; power of two; multiple of NUM_BANKS
- NUM_BANKS, 4, interleave factor; power of two, >=2
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; not overridden
- AEMPTY_THR, 4, almost-empty threshold (entries)
- AFULL_THR, 28, almost-full threshold (entries)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush_i  in  1  synchronous clear of all contents
- wen_i  in  1  write request
- wdata_i  in  DATA_WIDTH  write data
- full_o  out  1  current write bank cannot accept data
- afull_o  out  1  count_o >= AFULL_THR
- ren_i  in  1  read/pop request
- rdata_o  out  DATA_WIDTH  head data, valid whenever empty_o=0
- empty_o  out  1  current read bank has no visible head
- aempty_o  out  1  count_o <= AEMPTY_THR
- count_o  out  ADDR_WIDTH+1  accepted writes minus accepted reads
- err_o  out  2  {overflow, underflow}, sticky

Behaviour:
- Reset (rst=1, async): wr/rd bank pointers=0, count=0, all banks empty. Output values during reset:
  - empty_o=1, full_o=0, aempty_o=1, afull_o=0 (when AFULL_THR>0)
  - count_o=0, err_o=0, rdata_o=0
- Bank select: write bank = wptr[log2(NUM_BANKS)-1:0]; read bank = rptr low bits.
  - Only the selected bank sees wen/ren.
  - full_o and empty_o are muxed from the selected banks.
  - rdata_o is muxed from the read bank.
- Accept rules:
  - Write accepted iff wen_i & ~full_o; accepted write increments wptr (wraps at 2*FIFO_DEPTH).
  - Read accepted iff ren_i & ~empty_o; accepted read increments rptr.
  - Rejected requests change no state.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither. Range 0..FIFO_DEPTH; never wraps.
- FWFT latency:
  - A write accepted at cycle N into an empty FIFO drives empty_o=0 and rdata_o=wdata at cycle N+2.
  - count_o updates at N+1, so count_o may be >0 while empty_o=1.
- Back-to-back:
  - Sustained 1 write/cycle and 1 read/cycle, with no bubbles, once the FIFO holds >=NUM_BANKS entries.
  - Simultaneous read and write to the same bank index is legal; the bank arbitrates internally via its prefetch register.
- Full: full_o=1 when the current write bank is full. This happens exactly when count reaches FIFO_DEPTH in round-robin operation.
- Flush (flush_i=1):
  - Next cycle: pointers=0, count=0, banks empty, err_o preserved.
  - Flush overrides wen_i/ren_i in the same cycle; neither is accepted.
- Thresholds: aempty_o and afull_o are combinational from registered count (no extra latency).
- Reset mid-operation: all data discarded; the state after reset deassertion is identical to power-up.

Optional Feature:
- Macro FIFO_FWFT_ERR_FLAGS_EN.
- Defined:
  - err_o[1] sets on wen_i & full_o & ~flush_i.
  - err_o[0] sets on ren_i & empty_o & ~flush_i.
  - Both bits are sticky until rst; flush_i does not clear them.
- Undefined: err_o tied to 0; no flag registers are synthesised.

Decomposition:
- Package fifo_fwft_pkg:
  - BANK_SEL_W = $clog2(NUM_BANKS) helper function
  - err_o bit-index localparams (ERR_OVF=1, ERR_UDF=0)
  - Elaboration-time check function for the power-of-two rules
- One sub-module: fifo_spram_bank.
  - Depth FIFO_DEPTH/NUM_BANKS, single-port RAM plus a 1-entry output prefetch register.
  - FWFT interface: wen, wdata, full_o, ren, rdata, empty_o, flush.
  - Instantiated NUM_BANKS times in a generate loop.

Test Plan:
- Reset, single write 0xA5 at cycle 0, ren_i low -> count_o=1 at cycle 1; empty_o=0 and rdata_o=0xA5 at cycle 2.
- Write 32 entries 0..31 (DEPTH=32, 4 banks), then read all -> full_o=1 after the 32nd write; afull_o=1 from count 28; data reads out 0..31 in order; empty_o=1 and aempty_o=1 at end.
- Prefill 8 entries, then 100 cycles of simultaneous wen/ren -> count_o stays 8, no stalls, output order preserved across pointer wrap.
- With FIFO full, assert wen_i one cycle (FIFO_FWFT_ERR_FLAGS_EN defined) -> no state change, err_o=2'b10. Then flush and read while empty -> err_o=2'b11.
- Prefill 10 entries, assert flush_i with wen_i=ren_i=1 -> next cycle count_o=0, empty_o=1, neither request accepted.
- Assert rst asynchronously mid-stream with 12 entries held -> outputs go immediately to reset values; after release, first write 0x3C reads back correctly at write-cycle+2.
